// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Request / response / memory-port bundle of the load-store
//                unit. The slave modport is the unit's view; the master
//                modport is the view of whoever drives requests and serves
//                the memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8
);
    localparam int LANE_W = $clog2(XLEN / 8);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [ADDR_W-1:0]        req_addr;
    logic [XLEN-1:0]          req_wdata;
    logic                     rsp_valid;
    logic [XLEN-1:0]          rsp_rdata;
    logic                     rsp_misaligned;
    logic                     mem_re;
    logic                     mem_we;
    logic [ADDR_W-LANE_W-1:0] mem_addr;
    logic [XLEN-1:0]          mem_wdata;
    logic [XLEN-1:0]          mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr,
               req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr,
               req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
               mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-request load/store unit in front of a word-wide
//                synchronous memory. Handles byte/half/word accesses with
//                sign or zero extension, read-modify-write for sub-word
//                stores and misalignment faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus
);
    localparam int LANE_W = $clog2(XLEN / 8);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_write;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_rdata;
    logic                r_mis;

    logic                w_req_mis;
    logic [LANE_W-1:0]   w_req_lane;
    logic [LANE_W+2:0]   w_shamt;
    logic [XLEN-1:0]     w_rd_sh;
    logic [XLEN-1:0]     w_load;
    logic [XLEN-1:0]     w_bmask;
    logic [XLEN-1:0]     w_wmask;
    logic [XLEN-1:0]     w_merged;
    logic                w_mem_re;
    logic                w_mem_we;
    logic [XLEN-1:0]     w_mem_wdata;
    logic                w_rsp_upd;
    logic [XLEN-1:0]     w_rsp_rdata_nxt;
    logic                w_rsp_mis_nxt;

    // Fault detection on the incoming request, evaluated at accept time.
    always_comb begin
        w_req_lane = bus.req_addr[LANE_W-1:0];
        w_req_mis  = 1'b0;
        case (bus.req_size)
            2'd0:    w_req_mis = (w_req_lane != '0);
            2'd1:    w_req_mis = 1'b0;
            2'd2:    w_req_mis = bus.req_addr[0];
            default: w_req_mis = (XLEN == 32) || (bus.req_addr[1:0] != 2'b00);
        endcase
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        w_shamt = {r_addr[LANE_W-1:0], 3'b000};
        w_rd_sh = bus.mem_rdata >> w_shamt;
        case (r_size)
            2'd1: w_load = r_unsigned ? XLEN'(w_rd_sh[7:0])  : XLEN'($signed(w_rd_sh[7:0]));
            2'd2: w_load = r_unsigned ? XLEN'(w_rd_sh[15:0]) : XLEN'($signed(w_rd_sh[15:0]));
            2'd3: w_load = r_unsigned ? XLEN'(w_rd_sh[31:0]) : XLEN'($signed(w_rd_sh[31:0]));
            default: w_load = bus.mem_rdata;
        endcase
        case (r_size)
            2'd1:    w_bmask = XLEN'(8'hFF);
            2'd2:    w_bmask = XLEN'(16'hFFFF);
            2'd3:    w_bmask = XLEN'(32'hFFFF_FFFF);
            default: w_bmask = '1;
        endcase
        w_wmask  = w_bmask << w_shamt;
        w_merged = (bus.mem_rdata & ~w_wmask) | ((r_wdata << w_shamt) & w_wmask);
    end

    // Next-state and per-state strobes; the response registers are loaded
    // only on the edge that enters RESP so they hold between responses.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_re        = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_wdata     = '0;
        w_rsp_upd       = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_rsp_mis_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_mis) begin
                        w_state_nxt   = ST_RESP;
                        w_rsp_upd     = 1'b1;
                        w_rsp_mis_nxt = 1'b1;
                    end else if (bus.req_write && (bus.req_size == 2'd0)) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                w_mem_re    = 1'b1;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_rsp_upd = 1'b1;
                if (r_write) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = w_merged;
                end else begin
                    w_rsp_rdata_nxt = w_load;
                end
                w_state_nxt = ST_RESP;
            end
            ST_WR: begin
                w_mem_we    = 1'b1;
                w_mem_wdata = r_wdata;
                w_rsp_upd   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Capture the request fields on the accept edge only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if ((r_state == ST_IDLE) && bus.req_valid) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
        end
    end

    // Response data/fault registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else if (w_rsp_upd) begin
            r_rdata <= w_rsp_rdata_nxt;
            r_mis   <= w_rsp_mis_nxt;
        end
    end

    // Outputs are gated by reset so an aborted request never reaches memory.
    assign bus.req_ready      = (r_state == ST_IDLE) && !reset;
    assign bus.rsp_valid      = (r_state == ST_RESP) && !reset;
    assign bus.rsp_rdata      = reset ? '0 : r_rdata;
    assign bus.rsp_misaligned = r_mis && !reset;
    assign bus.mem_re         = w_mem_re && !reset;
    assign bus.mem_we         = w_mem_we && !reset;
    assign bus.mem_wdata      = reset ? '0 : w_mem_wdata;
    assign bus.mem_addr       = r_addr[ADDR_W-1:LANE_W];
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning byte-address width.
REQ-003 SHALL define derived constant LANE_W = log2(XLEN/8): 2 for XLEN=32, 3 for XLEN=64.
REQ-004 SHALL have port: clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: req_valid  in  1  request present.
REQ-007 SHALL have port: req_ready  out  1  unit can accept a request.
REQ-008 SHALL have port: req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port: req_size  in  2  access size: 0 = full word (XLEN), 1 = byte, 2 = half, 3 = 32-bit word (legal only when XLEN=64).
REQ-010 SHALL have port: req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
REQ-011 SHALL have port: req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port: req_wdata  in  XLEN  store data, right-aligned.
REQ-013 SHALL have port: rsp_valid  out  1  one-cycle response strobe.
REQ-014 SHALL have port: rsp_rdata  out  XLEN  load result; 0 for stores and faults.
REQ-015 SHALL have port: rsp_misaligned  out  1  request faulted; valid with rsp_valid.
REQ-016 SHALL have port: mem_re  out  1  memory read strobe.
REQ-017 SHALL have port: mem_we  out  1  memory write strobe.
REQ-018 SHALL have port: mem_addr  out  ADDR_W-LANE_W  word address, equal to req_addr >> LANE_W.
REQ-019 SHALL have port: mem_wdata  out  XLEN  full-word write data.
REQ-020 SHALL have port: mem_rdata  in  XLEN  read data, valid the cycle after mem_re.

Function
REQ-021 SHALL implement FSM states IDLE, RD, DATA, WR, RESP; req_ready = 1 only in IDLE.
REQ-022 SHALL, in IDLE with req_valid=1, latch all req_* fields at the edge and leave IDLE.
REQ-023 SHALL, on accept, treat the request as misaligned when: half with addr[0]=1; size 3 with addr[1:0]!=0; full word with addr[LANE_W-1:0]!=0; or size 3 when XLEN=32. It SHALL then go directly to RESP, with no mem_re or mem_we.
REQ-024 SHALL go IDLE->WR for an aligned full-word store; in WR, mem_we=1 and mem_wdata=latched wdata for exactly one cycle; then go to RESP.
REQ-025 SHALL go IDLE->RD for any aligned load or any aligned sub-word store; in RD, mem_re=1 for exactly one cycle; then go to DATA.
REQ-026 SHALL, in DATA for a load, shift mem_rdata right by 8*lane (lane = addr[LANE_W-1:0]), sign- or zero-extend 8/16/32 bits per size and req_unsigned (full word is unmodified), register the result into rsp_rdata, then go to RESP.
REQ-027 SHALL, in DATA for a sub-word store, assert mem_we for one cycle. mem_wdata SHALL equal mem_rdata with only the addressed byte lanes replaced by the low bytes of wdata, shifted left by 8*lane; all other lanes SHALL be unchanged. Then go to RESP.
REQ-028 SHALL, in RESP, assert rsp_valid for exactly one cycle and go to IDLE; rsp_misaligned SHALL be 1 only for faulted requests.
REQ-029 SHALL hold rsp_rdata and rsp_misaligned stable until the next RESP.
REQ-030 SHALL keep mem_addr constant from the RD cycle through the DATA cycle of the same request.
REQ-031 SHALL ignore req_valid outside IDLE; requests are not queued.
REQ-032 SHALL meet these latencies from the accept edge to the rsp_valid cycle: fault 1 cycle, full-word store 2, load or sub-word store 3.
REQ-033 SHALL never assert mem_re and mem_we in the same cycle.

Reset
REQ-034 SHALL, while reset=1, force state IDLE, and rsp_valid, rsp_misaligned, mem_re, mem_we=0; rsp_rdata, mem_wdata=0.
REQ-035 SHALL hold req_ready=0 while reset=1, and req_ready=1 the first cycle after reset is deasserted.
REQ-036 SHALL, on reset in any state, abandon the in-flight request: no mem_we and no rsp_valid for it.

Verification (XLEN=32, word 0x8899AABB at byte addr 0x10)
REQ-037 SHALL cover: LB addr 0x12 -> rsp_rdata 0xFFFFFF99; LBU addr 0x12 -> 0x00000099; rsp_valid 3 cycles after accept.
REQ-038 SHALL cover: LH addr 0x12 -> 0xFFFF8899; LHU -> 0x00008899; LW addr 0x10 -> 0x8899AABB.
REQ-039 SHALL cover: SB addr 0x11, wdata 0x000000CC -> one mem_we, mem_addr 0x04, mem_wdata 0x8899CCBB; then SH addr 0x12, wdata 0x1234 -> 0x1234CCBB.
REQ-040 SHALL cover: SH addr 0x13, and LW addr 0x12 -> rsp_misaligned=1, rsp_rdata=0, no mem_re/mem_we, rsp_valid 1 cycle after accept.
REQ-041 SHALL cover: SW 0xDEADBEEF addr 0x14 -> no mem_re, one mem_we, mem_addr 0x05, rsp_valid 2 cycles after accept; with XLEN=64, size-3 load at byte addr 0x0C -> upper 32 bits of the word, sign-extended.
REQ-042 SHALL cover: reset asserted during DATA of an SB -> mem_we=0, no rsp_valid, memory unchanged, req_ready=1 the cycle after reset is deasserted.
